// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer on the CPU native bus: 16-bit prescaler,
// 32-bit down-counter (one-shot or auto-reload), sticky expiry flag and IRQ level.
module mmio_timer #(
    parameter logic [31:0] ADDR = 32'h4000_7000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        timer_sel,
    output logic        timer_ready,
    output logic [31:0] timer_rdata,
    output logic        timer_irq
);

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_LOAD     = 6'h01;
    localparam logic [5:0] OFF_COUNT    = 6'h02;
    localparam logic [5:0] OFF_STATUS   = 6'h03;
    localparam logic [5:0] OFF_PRESCALE = 6'h04;

    typedef enum logic {IDLE, ACK} bus_state_t;

    bus_state_t  state;
    bus_state_t  state_next;
    logic        capture;
    logic [5:0]  offset;
    logic        unused_addr_bits;

    logic [2:0]  ctrl;
    logic [31:0] load;
    logic [31:0] count;
    logic [15:0] prescale;
    logic [15:0] pre;
    logic        expired;

    logic        en;
    logic        auto_reload;
    logic        ie;
    logic        tick;
    logic        expire_now;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_count;
    logic        wr_status;
    logic        wr_prescale;
    logic [31:0] read_value;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  strb);
        logic [31:0] result;
        result = old_value;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) result[8*b +: 8] = new_value[8*b +: 8];
        end
        return result;
    endfunction

    assign timer_sel        = mem_valid && (mem_addr[31:8] == ADDR[31:8]);
    assign offset           = mem_addr[7:2];
    assign unused_addr_bits = ^mem_addr[1:0];
    assign timer_ready      = (state == ACK);

    assign en          = ctrl[0];
    assign auto_reload = ctrl[1];
    assign ie          = ctrl[2];
    assign tick        = en && (pre == prescale);
    assign expire_now  = tick && (count == 32'd0);

    // Writes commit on the same edge that raises timer_ready.
    assign wr          = capture && (mem_wstrb != 4'd0);
    assign wr_ctrl     = wr && (offset == OFF_CTRL) && mem_wstrb[0];
    assign wr_load     = wr && (offset == OFF_LOAD);
    assign wr_count    = wr && (offset == OFF_COUNT);
    assign wr_status   = wr && (offset == OFF_STATUS) && mem_wstrb[0];
    assign wr_prescale = wr && (offset == OFF_PRESCALE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (timer_sel) begin
                    state_next = ACK;
                    capture    = 1'b1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_value = 32'd0;
        case (offset)
            OFF_CTRL:     read_value = {29'd0, ctrl};
            OFF_LOAD:     read_value = load;
            OFF_COUNT:    read_value = count;
            OFF_STATUS:   read_value = {31'd0, expired};
            OFF_PRESCALE: read_value = {16'd0, prescale};
            default:      read_value = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)        timer_rdata <= 32'd0;
        else if (capture) timer_rdata <= read_value;
    end

    // A bus write to CTRL overrides the one-shot auto-clear of EN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          ctrl <= 3'd0;
        else if (wr_ctrl)                   ctrl <= mem_wdata[2:0];
        else if (expire_now && !auto_reload) ctrl[0] <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load     <= 32'd0;
            prescale <= 16'd0;
        end else begin
            if (wr_load) load <= merge_bytes(load, mem_wdata, mem_wstrb);
            if (wr_prescale) begin
                prescale <= {mem_wstrb[1] ? mem_wdata[15:8] : prescale[15:8],
                             mem_wstrb[0] ? mem_wdata[7:0]  : prescale[7:0]};
            end
        end
    end

    // pre free-runs across 2^16 if PRESCALE is lowered below it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                         pre <= 16'd0;
        else if (!en || tick || (wr_ctrl && !mem_wdata[0])) pre <= 16'd0;
        else                                               pre <= pre + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)             count <= 32'd0;
        else if (wr_count)     count <= merge_bytes(count, mem_wdata, mem_wstrb);
        else if (tick) begin
            if (count != 32'd0) count <= count - 32'd1;
            else if (auto_reload) count <= load;
        end
    end

    // Expiry set takes priority over a same-edge W1C clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          expired <= 1'b0;
        else if (expire_now)                expired <= 1'b1;
        else if (wr_status && mem_wdata[0]) expired <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) timer_irq <= 1'b0;
        else       timer_irq <= expired && ie;
    end

endmodule
